// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the ALU execution unit.
// Also used by the ALU control decode that produces the opcodes.
package alu_pkg;

    localparam int ALU_DATA_W  = 32;
    localparam int ALU_SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_SUB = 4'b0001,
        OP_ADD = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SLT = 4'b0101,
        OP_SLL = 4'b0110,
        OP_SRA = 4'b0111,
        OP_BEQ = 4'b1000,
        OP_SRL = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        HOLD  = 2'b10
    } alu_state_e;

    function automatic logic is_shift_op(input alu_op_e op);
        logic r;
        case (op)
            OP_SLL, OP_SRA, OP_SRL: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_legal_op(input logic [3:0] code);
        logic r;
        case (alu_op_e'(code))
            OP_AND, OP_SUB, OP_ADD, OP_OR, OP_XOR,
            OP_SLT, OP_SLL, OP_SRA, OP_BEQ, OP_SRL: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the datapath and the ALU execution unit.
interface alu_exec_unit_if
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        Operation;
    logic [DATA_W-1:0] SrcA;
    logic [DATA_W-1:0] SrcB;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ALUResult;
    logic              Zero;
    logic              Illegal;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, Illegal
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero, Illegal
    );
endinterface

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter: loads a value and amount on start,
// then shifts once per cycle until the counter runs out.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               dir,
    input  logic               arith,
    input  logic [DATA_W-1:0]  din,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               done,
    output logic [DATA_W-1:0]  shift_next
);

    logic [DATA_W-1:0]  work_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic               dir_r;
    logic               arith_r;
    logic [DATA_W-1:0]  step_s;

    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};

    // One-bit step of the working register in the latched direction
    always_comb begin
        step_s = work_r;
        if (dir_r) begin
            step_s = {(arith_r & work_r[DATA_W-1]), work_r[DATA_W-1:1]};
        end else begin
            step_s = {work_r[DATA_W-2:0], 1'b0};
        end
    end

    assign done       = (cnt_r == CNT_ONE);
    assign shift_next = step_s;

    // Working register and remaining-shift counter
    always_ff @(posedge clk) begin
        if (reset) begin
            work_r  <= {DATA_W{1'b0}};
            cnt_r   <= CNT_ZERO;
            dir_r   <= 1'b0;
            arith_r <= 1'b0;
        end else if (start) begin
            work_r  <= din;
            cnt_r   <= shamt;
            dir_r   <= dir;
            arith_r <= arith;
        end else if (cnt_r != CNT_ZERO) begin
            work_r  <= step_s;
            cnt_r   <= cnt_r - CNT_ONE;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: captures one request, computes single-cycle ops inline
// or runs an iterative shift, then holds the result until it is popped.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_unit_if.slave bus
);

    alu_state_e         state_r;
    alu_state_e         next_state_s;
    alu_op_e            op_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic               accept_s;
    logic               shift_long_s;
    logic               shift_start_s;
    logic               shift_done_s;
    logic [DATA_W-1:0]  shift_next_s;
    logic               slt_s;
    logic [DATA_W-1:0]  calc_s;
    logic [DATA_W-1:0]  result_r;
    logic               zero_r;
    logic               illegal_r;
    logic               in_ready_s;
    logic               out_valid_s;

    assign op_s          = alu_op_e'(bus.Operation);
    assign shamt_s       = bus.SrcB[SHAMT_W-1:0];
    assign accept_s      = (state_r == IDLE) && bus.in_valid;
    assign shift_long_s  = is_shift_op(op_s) && (shamt_s != {SHAMT_W{1'b0}});
    assign shift_start_s = accept_s && is_shift_op(op_s);
    assign slt_s         = ($signed(bus.SrcA) < $signed(bus.SrcB));

    alu_shift_iter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .start      (shift_start_s),
        .dir        (op_s != OP_SLL),
        .arith      (op_s == OP_SRA),
        .din        (bus.SrcA),
        .shamt      (shamt_s),
        .done       (shift_done_s),
        .shift_next (shift_next_s)
    );

    // Single-cycle result; a zero-amount shift simply passes SrcA through
    always_comb begin
        calc_s = {DATA_W{1'b0}};
        case (op_s)
            OP_AND:                 calc_s = bus.SrcA & bus.SrcB;
            OP_SUB, OP_BEQ:         calc_s = bus.SrcA - bus.SrcB;
            OP_ADD:                 calc_s = bus.SrcA + bus.SrcB;
            OP_OR:                  calc_s = bus.SrcA | bus.SrcB;
            OP_XOR:                 calc_s = bus.SrcA ^ bus.SrcB;
            OP_SLT:                 calc_s = {{(DATA_W-1){1'b0}}, slt_s};
            OP_SLL, OP_SRA, OP_SRL: calc_s = bus.SrcA;
            default:                calc_s = {DATA_W{1'b0}};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    if (shift_long_s) begin
                        next_state_s = SHIFT;
                    end else begin
                        next_state_s = HOLD;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (shift_done_s) begin
                    next_state_s = HOLD;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM handshake outputs, decoded from the registered state
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            SHIFT: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
            HOLD: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Result/flag registers: loaded at acceptance, or at the last shift step
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r  <= {DATA_W{1'b0}};
            zero_r    <= 1'b1;
            illegal_r <= 1'b0;
        end else if (accept_s) begin
            if (shift_long_s) begin
                illegal_r <= 1'b0;
            end else begin
                result_r  <= calc_s;
                zero_r    <= (calc_s == {DATA_W{1'b0}});
                illegal_r <= !is_legal_op(bus.Operation);
            end
        end else if ((state_r == SHIFT) && shift_done_s) begin
            result_r <= shift_next_s;
            zero_r   <= (shift_next_s == {DATA_W{1'b0}});
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.ALUResult = result_r;
    assign bus.Zero      = zero_r;
    assign bus.Illegal   = illegal_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and randomized checks of alu_exec_unit against a plain-arithmetic
// reference of the opcode table and latency rules.
module tb_alu_exec_unit;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    alu_exec_unit_if #(.DATA_W(32)) bus ();

    alu_exec_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a - b;
            4'd2:    return a + b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return a << sh;
            4'd7:    return $signed(a) >>> sh;
            4'd8:    return a - b;
            4'd9:    return a >> sh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_extra(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd6 || op == 4'd7 || op == 4'd9) return int'(b[4:0]);
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.Operation = op;
        bus.SrcA      = a;
        bus.SrcB      = b;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_extra);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            chk({tag, "_busy_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
            tick();
            n++;
        end
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_latency"}, n, exp_extra);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] res, input logic ill);
        chk({tag, "_result"}, bus.ALUResult, res);
        chk({tag, "_zero"}, {31'd0, bus.Zero}, {31'd0, (res == 32'd0)});
        chk({tag, "_illegal"}, {31'd0, bus.Illegal}, {31'd0, ill});
        chk({tag, "_hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    endtask

    task automatic pop(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_pop_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_pop_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic ill, input int extra);
        send(tag, op, a, b);
        wait_out(tag, extra);
        expect_out(tag, res, ill);
        pop(tag);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_result"}, bus.ALUResult, 32'd0);
        chk({tag, "_zero"}, {31'd0, bus.Zero}, 32'd1);
        chk({tag, "_illegal"}, {31'd0, bus.Illegal}, 32'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.Operation = 4'd0;
        bus.SrcA      = 32'd0;
        bus.SrcB      = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_state("reset");

        run("add",   4'd2, 32'd5,          32'd7,          32'd12,         1'b0, 0);
        run("beq",   4'd8, 32'h10,         32'h10,         32'd0,          1'b0, 0);
        run("slt",   4'd5, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 0);
        run("sra4",  4'd7, 32'h8000_0000,  32'h24,         32'hF800_0000,  1'b0, 4);
        run("srl4",  4'd9, 32'h8000_0000,  32'h24,         32'h0800_0000,  1'b0, 4);
        run("sll0",  4'd6, 32'h1234,       32'h20,         32'h1234,       1'b0, 0);
        run("sll31", 4'd6, 32'd1,          32'd31,         32'h8000_0000,  1'b0, 31);
        run("sub",   4'd1, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 0);

        // Backpressure: result held while in_valid is offered and ignored
        send("bp", 4'd2, 32'd3, 32'hFFFF_FFFD);
        wait_out("bp", 0);
        for (int i = 0; i < 3; i++) begin
            bus.Operation = 4'd3;
            bus.SrcA      = 32'hAAAA_0000;
            bus.SrcB      = 32'h0000_5555;
            bus.in_valid  = 1'b1;
            tick();
            expect_out("bp_stall", 32'd0, 1'b0);
            chk("bp_stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.in_valid = 1'b0;
        pop("bp");
        tick();
        chk("bp_no_ghost", {31'd0, bus.out_valid}, 32'd0);
        run("after_bp", 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 0);

        run("illegal",   4'd15, 32'h55, 32'h66, 32'd0, 1'b1, 0);
        run("ill_clear", 4'd2,  32'd1,  32'd2,  32'd3, 1'b0, 0);

        // Reset in the middle of a long shift discards the result
        send("rst_shift", 4'd6, 32'd1, 32'd20);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_state("rst_shift");
        for (int i = 0; i < 24; i++) begin
            tick();
            chk("rst_shift_no_stale", {31'd0, bus.out_valid}, 32'd0);
        end

        // Reset while holding an illegal result
        send("rst_hold", 4'd12, 32'd9, 32'd9);
        wait_out("rst_hold", 0);
        chk("rst_hold_illegal_set", {31'd0, bus.Illegal}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_state("rst_hold");

        // in_valid together with reset is not accepted
        reset         = 1'b1;
        bus.Operation = 4'd2;
        bus.SrcA      = 32'd1;
        bus.SrcB      = 32'd1;
        bus.in_valid  = 1'b1;
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        chk_reset_state("rst_valid");
        tick();
        chk("rst_valid_not_taken", {31'd0, bus.out_valid}, 32'd0);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 0) b = b & 32'h0000_0003;
            run("rand", op, a, b, ref_res(op, a, b), (op > 4'd9), ref_extra(op, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
